// File: rtl/axi_rd_resp.sv
// axi_rd_resp: matches AXI R beats to outstanding AR transactions by ID and forwards tagged, addressed beats.
module axi_rd_resp #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     trans_wr,
  input  logic [96:0]              trans_wrdata,
  output logic                     trans_full,
  input  logic                     axi_rvalid,
  output logic                     axi_rready,
  input  logic [5:0]               axi_rid,
  input  logic [DATA_W-1:0]        axi_rdata,
  input  logic [1:0]               axi_rresp,
  input  logic                     axi_rlast,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [11:0]              rsp_tag,
  output logic [63:0]              rsp_addr,
  output logic [7:0]               rsp_beat,
  output logic                     rsp_last,
  output logic [1:0]               rsp_resp,
  output logic                     err_unexp_id,
  output logic                     err_len,
  output logic                     err_ovf,
  output logic [$clog2(DEPTH):0]   outstanding
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [5:0]  id_q [DEPTH], id_d [DEPTH];
  logic [63:0] addr_q [DEPTH], addr_d [DEPTH];
  logic [7:0]  len_q [DEPTH], len_d [DEPTH];
  logic [2:0]  size_q [DEPTH], size_d [DEPTH];
  logic [11:0] tag_q [DEPTH], tag_d [DEPTH];
  logic [7:0]  beat_cnt_q [DEPTH], beat_cnt_d [DEPTH];
  logic [AW-1:0] order_q [DEPTH], order_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, new_order;
  logic rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [11:0] rsp_tag_q, rsp_tag_d;
  logic [63:0] rsp_addr_q, rsp_addr_d;
  logic [7:0]  rsp_beat_q, rsp_beat_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic err_unexp_id_q, err_unexp_id_d, err_len_q, err_len_d, err_ovf_q, err_ovf_d;
  logic hit, acc, match, at_len, free, alloc;
  logic [AW-1:0] hit_idx, slot;
  logic unused_rsvd;
  assign unused_rsvd = ^trans_wrdata[96:93];
  assign trans_full = cnt_q == CW'(DEPTH);
  assign axi_rready = ~rsp_valid_q | rsp_ready;
  always_comb begin
    valid_d = valid_q;
    id_d = id_q;
    addr_d = addr_q;
    len_d = len_q;
    size_d = size_q;
    tag_d = tag_q;
    beat_cnt_d = beat_cnt_q;
    order_d = order_q;
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && id_q[i] == axi_rid && order_q[i] == '0) begin
        hit = 1'b1;
        hit_idx = AW'(i);
      end
    acc = axi_rvalid & axi_rready;
    match = acc & hit;
    at_len = beat_cnt_q[hit_idx] == len_q[hit_idx];
    free = match & (axi_rlast | at_len);
    alloc = trans_wr & ~trans_full;
    slot = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_q[i]) slot = AW'(i);
    // Queue position among same-ID survivors; an entry freed this cycle no longer counts.
    new_order = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && id_q[i] == trans_wrdata[80:75] && !(free && AW'(i) == hit_idx))
        new_order = new_order + CW'(1);
    if (match) beat_cnt_d[hit_idx] = beat_cnt_q[hit_idx] + 8'd1;
    if (free) begin
      valid_d[hit_idx] = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        if (valid_q[i] && id_q[i] == axi_rid && order_q[i] != '0)
          order_d[i] = order_q[i] - AW'(1);
    end
    if (alloc) begin
      valid_d[slot] = 1'b1;
      addr_d[slot] = trans_wrdata[63:0];
      len_d[slot] = trans_wrdata[71:64];
      size_d[slot] = trans_wrdata[74:72];
      id_d[slot] = trans_wrdata[80:75];
      tag_d[slot] = trans_wrdata[92:81];
      beat_cnt_d[slot] = 8'd0;
      order_d[slot] = AW'(new_order);
    end
    cnt_d = cnt_q + CW'(alloc) - CW'(free);
    rsp_valid_d = match | (rsp_valid_q & ~rsp_ready);
    rsp_data_d = match ? axi_rdata : rsp_data_q;
    rsp_tag_d = match ? tag_q[hit_idx] : rsp_tag_q;
    rsp_addr_d = match ? addr_q[hit_idx] + (64'(beat_cnt_q[hit_idx]) << size_q[hit_idx]) : rsp_addr_q;
    rsp_beat_d = match ? beat_cnt_q[hit_idx] : rsp_beat_q;
    rsp_last_d = match ? free : rsp_last_q;
    rsp_resp_d = match ? axi_rresp : rsp_resp_q;
    err_unexp_id_d = acc & ~hit;
    err_len_d = match & (axi_rlast ^ at_len);
    err_ovf_d = trans_wr & trans_full;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= '0;
        addr_q[i] <= '0;
        len_q[i] <= '0;
        size_q[i] <= '0;
        tag_q[i] <= '0;
        beat_cnt_q[i] <= '0;
        order_q[i] <= '0;
      end
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_tag_q <= '0;
      rsp_addr_q <= '0;
      rsp_beat_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_resp_q <= '0;
      err_unexp_id_q <= 1'b0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      id_q <= id_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      tag_q <= tag_d;
      beat_cnt_q <= beat_cnt_d;
      order_q <= order_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_beat_q <= rsp_beat_d;
      rsp_last_q <= rsp_last_d;
      rsp_resp_q <= rsp_resp_d;
      err_unexp_id_q <= err_unexp_id_d;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
    end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_tag = rsp_tag_q;
  assign rsp_addr = rsp_addr_q;
  assign rsp_beat = rsp_beat_q;
  assign rsp_last = rsp_last_q;
  assign rsp_resp = rsp_resp_q;
  assign err_unexp_id = err_unexp_id_q;
  assign err_len = err_len_q;
  assign err_ovf = err_ovf_q;
  assign outstanding = cnt_q;
endmodule

// File: tb/tb_axi_rd_resp.sv
// tb_axi_rd_resp: directed and random stimulus against an in-order-per-ID transaction list model.
module tb_axi_rd_resp;
  localparam int DEPTH = 8;
  localparam int DATA_W = 64;
  logic clk = 1'b0, resetn = 1'b0;
  logic trans_wr = 1'b0, trans_full;
  logic [96:0] trans_wrdata = '0;
  logic axi_rvalid = 1'b0, axi_rready, axi_rlast = 1'b0;
  logic [5:0] axi_rid = '0;
  logic [DATA_W-1:0] axi_rdata = '0;
  logic [1:0] axi_rresp = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_last;
  logic [DATA_W-1:0] rsp_data;
  logic [11:0] rsp_tag;
  logic [63:0] rsp_addr;
  logic [7:0] rsp_beat;
  logic [1:0] rsp_resp;
  logic err_unexp_id, err_len, err_ovf;
  logic [$clog2(DEPTH):0] outstanding;
  int checks = 0, failures = 0;
  typedef struct {
    logic [5:0] id;
    logic [63:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [11:0] tag;
    int cnt;
  } txn_t;
  txn_t q[$];
  logic m_valid, m_last, m_unexp, m_len, m_ovf;
  logic [63:0] m_data, m_addr;
  logic [11:0] m_tag;
  logic [7:0] m_beat;
  logic [1:0] m_resp;

  axi_rd_resp #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn), .trans_wr(trans_wr), .trans_wrdata(trans_wrdata),
    .trans_full(trans_full), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_addr(rsp_addr), .rsp_beat(rsp_beat), .rsp_last(rsp_last), .rsp_resp(rsp_resp),
    .err_unexp_id(err_unexp_id), .err_len(err_len), .err_ovf(err_ovf), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_last = 0; m_unexp = 0; m_len = 0; m_ovf = 0;
    m_data = 0; m_addr = 0; m_tag = 0; m_beat = 0; m_resp = 0;
  endtask

  function automatic int find_id(input logic [5:0] id);
    for (int i = 0; i < q.size(); i++) if (q[i].id == id) return i;
    return -1;
  endfunction

  // One clock: predict from the current inputs, then compare every output after the edge.
  task automatic tick();
    bit full, rdy;
    int k;
    txn_t t;
    full = q.size() == DEPTH;
    rdy = !m_valid || rsp_ready;
    #1;
    chk("axi_rready", 64'(axi_rready), 64'(rdy));
    chk("trans_full", 64'(trans_full), 64'(full));
    m_unexp = 0; m_len = 0;
    m_ovf = trans_wr && full;
    if (rsp_ready) m_valid = 0;
    if (axi_rvalid && rdy) begin
      k = find_id(axi_rid);
      if (k < 0) m_unexp = 1;
      else begin
        m_valid = 1;
        m_data = axi_rdata;
        m_tag = q[k].tag;
        m_beat = 8'(q[k].cnt);
        m_addr = q[k].addr + (64'(q[k].cnt) << q[k].size);
        m_resp = axi_rresp;
        m_last = axi_rlast || q[k].cnt == int'(q[k].len);
        m_len = axi_rlast != (q[k].cnt == int'(q[k].len));
        q[k].cnt = q[k].cnt + 1;
        if (m_last) q.delete(k);
      end
    end
    if (trans_wr && !full) begin
      t.addr = trans_wrdata[63:0]; t.len = trans_wrdata[71:64]; t.size = trans_wrdata[74:72];
      t.id = trans_wrdata[80:75]; t.tag = trans_wrdata[92:81]; t.cnt = 0;
      q.push_back(t);
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_tag", 64'(rsp_tag), 64'(m_tag));
    chk("rsp_addr", rsp_addr, m_addr);
    chk("rsp_beat", 64'(rsp_beat), 64'(m_beat));
    chk("rsp_last", 64'(rsp_last), 64'(m_last));
    chk("rsp_resp", 64'(rsp_resp), 64'(m_resp));
    chk("err_unexp_id", 64'(err_unexp_id), 64'(m_unexp));
    chk("err_len", 64'(err_len), 64'(m_len));
    chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
    chk("outstanding", 64'(outstanding), 64'(q.size()));
  endtask

  task automatic set_push(input logic [5:0] id, input logic [7:0] len, input logic [2:0] size,
                          input logic [63:0] addr, input logic [11:0] tag);
    trans_wr = 1;
    trans_wrdata = {4'h0, tag, id, size, len, addr};
  endtask

  task automatic push(input logic [5:0] id, input logic [7:0] len, input logic [2:0] size,
                      input logic [63:0] addr, input logic [11:0] tag);
    set_push(id, len, size, addr, tag);
    tick();
    trans_wr = 0;
  endtask

  task automatic beat(input logic [5:0] id, input logic last, input logic [1:0] resp);
    axi_rvalid = 1; axi_rid = id; axi_rlast = last; axi_rresp = resp;
    axi_rdata = {$urandom, $urandom};
    tick();
    axi_rvalid = 0;
  endtask

  initial begin
    int k;
    model_reset();
    #12;
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_outstanding", 64'(outstanding), 0);
    chk("reset_rsp_addr", rsp_addr, 0);
    chk("reset_full", 64'(trans_full), 0);
    @(posedge clk); #1 resetn = 1;
    // Sequential burst addressing
    push(6'd3, 8'd3, 3'd3, 64'h1000, 12'hA);
    for (int i = 0; i < 4; i++) begin
      beat(6'd3, i == 3, 2'(i));
      chk("t1_addr", rsp_addr, 64'h1000 + 64'(8 * i));
      chk("t1_beat", 64'(rsp_beat), 64'(i));
    end
    chk("t1_last", 64'(rsp_last), 1);
    // Out-of-order return across IDs
    push(6'd1, 8'd0, 3'd2, 64'h40, 12'h1);
    push(6'd2, 8'd0, 3'd2, 64'h80, 12'h2);
    beat(6'd2, 1, 0); chk("t2_tag_a", 64'(rsp_tag), 64'h2);
    beat(6'd1, 1, 0); chk("t2_tag_b", 64'(rsp_tag), 64'h1);
    // Same-ID ordering plus alloc in the cycle the head frees
    push(6'd5, 8'd1, 3'd2, 64'h200, 12'h7);
    push(6'd5, 8'd1, 3'd2, 64'h300, 12'h8);
    beat(6'd5, 0, 0); chk("t3_tag0", 64'(rsp_tag), 64'h7);
    set_push(6'd5, 8'd1, 3'd2, 64'h400, 12'h7);
    beat(6'd5, 1, 0); trans_wr = 0;
    chk("t3_tag1", 64'(rsp_tag), 64'h7);
    beat(6'd5, 0, 0); chk("t3_tag2", 64'(rsp_tag), 64'h8);
    beat(6'd5, 1, 0); chk("t3_tag3", 64'(rsp_tag), 64'h8);
    beat(6'd5, 0, 0); chk("t3_tag4", 64'(rsp_tag), 64'h7);
    beat(6'd5, 1, 0); chk("t3_addr5", rsp_addr, 64'h404);
    // Unexpected ID and early RLAST
    beat(6'd9, 1, 0); chk("t4_unexp", 64'(err_unexp_id), 1);
    push(6'd6, 8'd2, 3'd0, 64'h10, 12'h66);
    beat(6'd6, 0, 0);
    beat(6'd6, 1, 0); chk("t4_err_len", 64'(err_len), 1); chk("t4_last", 64'(rsp_last), 1);
    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) push(6'(10 + i), 8'd0, 3'd0, 64'(i), 12'(i));
    chk("t5_full", 64'(trans_full), 1);
    push(6'd20, 8'd0, 3'd0, 64'h0, 12'h0);
    chk("t5_ovf", 64'(err_ovf), 1); chk("t5_outst", 64'(outstanding), 8);
    for (int i = 0; i < DEPTH; i++) beat(6'(10 + i), 1, 0);
    // Backpressure and 64-bit address wrap
    push(6'd4, 8'd1, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 12'h44);
    rsp_ready = 0;
    beat(6'd4, 0, 0);
    beat(6'd4, 1, 0); chk("t6_stall_beat", 64'(rsp_beat), 0);
    rsp_ready = 1;
    beat(6'd4, 1, 0); chk("t6_wrap", rsp_addr, 64'h0);
    tick();
    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      trans_wr = $urandom_range(0, 2) == 0;
      trans_wrdata = {4'($urandom), 12'($urandom), 6'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                      8'($urandom_range(0, 3)), $urandom, $urandom};
      axi_rvalid = $urandom_range(0, 1);
      axi_rid = (q.size() > 0 && $urandom_range(0, 9) < 8) ? q[$urandom_range(0, q.size() - 1)].id
                                                         : 6'($urandom_range(0, 5));
      k = find_id(axi_rid);
      axi_rlast = (k >= 0 && $urandom_range(0, 9) < 9) ? (q[k].cnt == int'(q[k].len)) : 1'($urandom);
      axi_rresp = 2'($urandom);
      axi_rdata = {$urandom, $urandom};
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    // Asynchronous reset in the middle of traffic
    trans_wr = 0; axi_rvalid = 1; rsp_ready = 0;
    #3 resetn = 0;
    #1;
    model_reset();
    chk("rst_mid_valid", 64'(rsp_valid), 0);
    chk("rst_mid_outst", 64'(outstanding), 0);
    @(posedge clk); #1 resetn = 1; axi_rvalid = 0; rsp_ready = 1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
